// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master round-robin Wishbone classic arbiter; optional watchdog via WB_ARB_TIMEOUT_EN
module wb_arbiter2 #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_sel,
  input  logic        m0_we,
  input  logic        m0_cyc,
  input  logic        m0_stb,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_sel,
  input  logic        m1_we,
  input  logic        m1_cyc,
  input  logic        m1_stb,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_sel,
  output logic        s_we,
  output logic        s_cyc,
  output logic        s_stb,
  input  logic [31:0] s_rdata,
  input  logic        s_ack
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t state;
  state_t next_state;
  logic   last;
  logic   timeout;

  // Reject watchdog limits the 16-bit counter cannot represent sensibly.
  if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_arbiter2: TIMEOUT_CYCLES must be within 4..65535");
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Watchdog: count stalled strobe cycles of the current grant; any ack, idle strobe or grant change restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
    end else if (state == IDLE || next_state != state || !s_stb || s_ack) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end

  assign timeout = (state != IDLE) && s_stb && !s_ack && (wd_cnt == 16'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  // State and round-robin history registers; last starts at 1 so m0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= next_state;
      if (next_state == GNT0) begin
        last <= 1'b0;
      end else if (next_state == GNT1) begin
        last <= 1'b1;
      end
    end
  end

  // Next grant: ties go to the master not served last; a grant is held until its cyc drops or the watchdog fires.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          next_state = last ? GNT0 : GNT1;
        end else if (m0_cyc) begin
          next_state = GNT0;
        end else if (m1_cyc) begin
          next_state = GNT1;
        end
      end
      GNT0: begin
        if (timeout) begin
          next_state = IDLE;
        end else if (!m0_cyc) begin
          next_state = m1_cyc ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (timeout) begin
          next_state = IDLE;
        end else if (!m1_cyc) begin
          next_state = m0_cyc ? GNT0 : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Zero-latency request mux and response routing; only the granted master sees the slave.
  always_comb begin
    s_addr   = '0;
    s_wdata  = '0;
    s_sel    = '0;
    s_we     = 1'b0;
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    m0_rdata = '0;
    m0_ack   = 1'b0;
    m0_err   = 1'b0;
    m1_rdata = '0;
    m1_ack   = 1'b0;
    m1_err   = 1'b0;
    case (state)
      GNT0: begin
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        s_sel    = m0_sel;
        s_we     = m0_we;
        s_cyc    = m0_cyc;
        s_stb    = m0_stb;
        m0_rdata = s_rdata;
        m0_ack   = s_ack && !timeout;
        m0_err   = timeout;
      end
      GNT1: begin
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        s_sel    = m1_sel;
        s_we     = m1_we;
        s_cyc    = m1_cyc;
        s_stb    = m1_stb;
        m1_rdata = s_rdata;
        m1_ack   = s_ack && !timeout;
        m1_err   = timeout;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - directed self-checking bench for wb_arbiter2 with a one-cycle-ack RAM model
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb;
  logic [31:0] s_rdata = '0;
  logic        s_ack = 1'b0;
  logic        ram_stall = 1'b0;
  logic [31:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  wb_arbiter2 #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel), .m0_we(m0_we),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel), .m1_we(m1_we),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_sel(s_sel), .s_we(s_we), .s_cyc(s_cyc), .s_stb(s_stb),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  always #5 clk = ~clk;

  // RAM slave: acks one cycle after cyc&stb, byte-lane writes, ignores arbiter reset.
  always @(posedge clk) begin
    if (s_cyc && s_stb && !s_ack && !ram_stall) begin
      s_ack <= 1'b1;
      if (s_we) begin
        for (int b = 0; b < 4; b++)
          if (s_sel[b]) mem[s_addr[9:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      end else begin
        s_rdata <= mem[s_addr[9:2]];
      end
    end else begin
      s_ack <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0]  sel_v [3];
    logic [31:0] dat_v [3];
    sel_v[0] = 4'hF; sel_v[1] = 4'h3; sel_v[2] = 4'h8;
    dat_v[0] = 32'h12345678; dat_v[1] = 32'hFFFF9999; dat_v[2] = 32'h55000000;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h40] = 32'hDEADBEEF;
    mem[8'hC0] = 32'hAABBCCDD;
    m0_addr = '0; m0_wdata = '0; m0_sel = '0; m0_we = 0; m0_cyc = 0; m0_stb = 0;
    m1_addr = '0; m1_wdata = '0; m1_sel = '0; m1_we = 0; m1_cyc = 0; m1_stb = 0;
    reset_n = 0;
    step(); step();
    check("rst_s_cyc", 32'(s_cyc), 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_m0_ack", 32'(m0_ack), 0);
    check("rst_m1_ack", 32'(m1_ack), 0);
    check("rst_m0_err", 32'(m0_err), 0);
    reset_n = 1;
    step();

    // single m0 read
    m0_addr = 32'h100; m0_sel = 4'hF; m0_we = 0; m0_cyc = 1; m0_stb = 1;
    #1;
    check("t1_idle_s_cyc", 32'(s_cyc), 0);
    step();
    check("t1_gnt_s_cyc", 32'(s_cyc), 1);
    check("t1_gnt_s_addr", s_addr, 32'h100);
    check("t1_gnt_m0_ack", 32'(m0_ack), 0);
    step();
    check("t1_m0_ack", 32'(m0_ack), 1);
    check("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("t1_m1_ack", 32'(m1_ack), 0);
    check("t1_m1_rdata", m1_rdata, 0);
    m0_cyc = 0; m0_stb = 0;
    step();
    check("t1_rel_s_cyc", 32'(s_cyc), 0);

    // tie after reset: m0 first, then m1 without an idle bubble
    reset_n = 0; step(); reset_n = 1; step();
    m0_addr = 32'h100; m0_cyc = 1; m0_stb = 1;
    m1_addr = 32'h300; m1_sel = 4'hF; m1_we = 0; m1_cyc = 1; m1_stb = 1;
    step();
    check("t2_tie_m0_first", s_addr, 32'h100);
    step();
    check("t2_m0_ack", 32'(m0_ack), 1);
    check("t2_m1_ack_blocked", 32'(m1_ack), 0);
    m0_cyc = 0; m0_stb = 0;
    step();
    check("t2_handover_s_cyc", 32'(s_cyc), 1);
    check("t2_handover_s_addr", s_addr, 32'h300);
    step();
    check("t2_m1_ack", 32'(m1_ack), 1);
    check("t2_m1_rdata", m1_rdata, 32'hAABBCCDD);
    m1_cyc = 0; m1_stb = 0;
    step();
    // m0 alone makes m0 the last served; the next tie then goes to m1
    m0_cyc = 1; m0_stb = 1;
    step(); step();
    check("t2b_m0_ack", 32'(m0_ack), 1);
    m0_cyc = 0; m0_stb = 0;
    step();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    step();
    check("t2b_tie_m1_first", s_addr, 32'h300);
    step();
    check("t2b_m1_ack", 32'(m1_ack), 1);
    m1_cyc = 0; m1_stb = 0;
    step();
    check("t2b_handover_m0", s_addr, 32'h100);
    step();
    check("t2b_m0_ack", 32'(m0_ack), 1);
    m0_cyc = 0; m0_stb = 0;
    step();

    // m1 locks the bus for three byte-lane writes while m0 waits
    m1_addr = 32'h300; m1_we = 1; m1_sel = sel_v[0]; m1_wdata = dat_v[0]; m1_cyc = 1; m1_stb = 1;
    step();
    m0_addr = 32'h300; m0_we = 0; m0_sel = 4'hF; m0_cyc = 1; m0_stb = 1;
    for (int i = 0; i < 3; i++) begin
      m1_sel = sel_v[i]; m1_wdata = dat_v[i];
      #1;
      for (int n = 0; n < 8 && !m1_ack; n++) step();
      check($sformatf("t3_w%0d_m1_ack", i), 32'(m1_ack), 1);
      check($sformatf("t3_w%0d_s_sel", i), 32'(s_sel), 32'(sel_v[i]));
      check($sformatf("t3_w%0d_m0_blocked", i), 32'(m0_ack), 0);
      step();
    end
    m1_cyc = 0; m1_stb = 0;
    step();
    check("t3_m0_gnt_s_we", 32'(s_we), 0);
    check("t3_m0_gnt_s_cyc", 32'(s_cyc), 1);
    step();
    check("t3_rb_ack", 32'(m0_ack), 1);
    check("t3_rb_data", m0_rdata, 32'h55349999);
    m0_cyc = 0; m0_stb = 0; m1_we = 0;
    step();

    // m0 write with m1 toggling noise
    m0_addr = 32'h200; m0_wdata = 32'h11223344; m0_we = 1; m0_sel = 4'hF; m0_cyc = 1; m0_stb = 1;
    step();
    for (int i = 0; i < 4; i++) begin
      m1_addr = $urandom; m1_wdata = $urandom; m1_sel = 4'($urandom);
      m1_we = 1'($urandom_range(0, 1)); m1_cyc = 1'($urandom_range(0, 1)); m1_stb = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("t4_c%0d_s_addr", i), s_addr, 32'h200);
      check($sformatf("t4_c%0d_s_wdata", i), s_wdata, 32'h11223344);
      step();
    end
    m0_cyc = 0; m0_stb = 0; m0_we = 0;
    m1_addr = '0; m1_wdata = '0; m1_sel = '0; m1_we = 0; m1_cyc = 0; m1_stb = 0;
    step();
    m0_cyc = 1; m0_stb = 1;
    step(); step();
    check("t4_rb_ack", 32'(m0_ack), 1);
    check("t4_rb_data", m0_rdata, 32'h11223344);
    m0_cyc = 0; m0_stb = 0;
    step();

    // reset in the middle of a granted read while the slave ack is high
    m0_addr = 32'h100; m0_cyc = 1; m0_stb = 1;
    step(); step();
    #2;
    reset_n = 0;
    #1;
    check("t5_rst_s_cyc", 32'(s_cyc), 0);
    check("t5_rst_s_addr", s_addr, 0);
    check("t5_rst_m0_ack", 32'(m0_ack), 0);
    check("t5_rst_m0_rdata", m0_rdata, 0);
    step();
    check("t5_rst_hold_ack", 32'(m0_ack), 0);
    reset_n = 1;
    step();
    check("t5_regnt_s_cyc", 32'(s_cyc), 1);
    step();
    check("t5_regnt_ack", 32'(m0_ack), 1);
    check("t5_regnt_data", m0_rdata, 32'hDEADBEEF);
    m0_cyc = 0; m0_stb = 0;
    step();

    // stalled slave
    ram_stall = 1;
    m0_addr = 32'h100; m0_cyc = 1; m0_stb = 1;
    step();
    m1_addr = 32'h300; m1_we = 0; m1_cyc = 1; m1_stb = 1;
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      step();
      check($sformatf("t6_k%0d_m0_err", k), 32'(m0_err), 0);
    end
    step();
    check("t6_err_pulse", 32'(m0_err), 1);
    check("t6_err_no_ack", 32'(m0_ack), 0);
    check("t6_err_m1_err", 32'(m1_err), 0);
    step();
    check("t6_idle_s_cyc", 32'(s_cyc), 0);
    check("t6_idle_err_gone", 32'(m0_err), 0);
    step();
    check("t6_m1_wins", s_addr, 32'h300);
    ram_stall = 0;
    step();
    check("t6_m1_ack", 32'(m1_ack), 1);
    m1_cyc = 0; m1_stb = 0;
    step();
    m0_cyc = 0; m0_stb = 0;
    step();
`else
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("t6_k%0d_m0_err", k), 32'(m0_err), 0);
    end
    check("t6_hold_s_cyc", 32'(s_cyc), 1);
    check("t6_hold_s_addr", s_addr, 32'h100);
    ram_stall = 0;
    step();
    check("t6_late_ack", 32'(m0_ack), 1);
    m0_cyc = 0; m0_stb = 0;
    step();
    check("t6_handover_m1", s_addr, 32'h300);
    step();
    check("t6_m1_ack", 32'(m1_ack), 1);
    m1_cyc = 0; m1_stb = 0;
    step();
`endif
    check("end_idle_s_cyc", 32'(s_cyc), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
